// File: rtl/fsm_pkg.sv
// Shared definitions for the consecutive-ones frame family (transmitter and detectors).
package fsm_pkg;

  localparam int DEF_DATA_W       = 8;
  localparam int DEF_PREAMBLE_LEN = 3;

  // Transmitter state encoding; each state names what the line carries this cycle.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    GUARD = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } state_t;

endpackage

// File: rtl/seq_tx_shreg.sv
// Parallel-in serial-out register, MSB first. The shift enable is held low during stuff cycles.
// msb_next exposes the bit that becomes msb after a shift, so the top can register sout one cycle ahead.
module seq_tx_shreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         shift,
  output logic         msb,
  output logic         msb_next
);

  logic [W-1:0] q;

  // Load takes priority over shift; shifting moves the next payload bit into the MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift) begin
      q <= {q[W-2:0], 1'b0};
    end
  end

  assign msb      = q[W-1];
  assign msb_next = q[W-2];

endmodule

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: preamble of ones, guard zero, zero-stuffed payload MSB first, stop zero.
// Handshake: a word is accepted on a rising edge where in_valid && in_ready; in_ready is a
// registered decode of IDLE, so in_valid has no combinational path to any output.
module seq_frame_tx
  import fsm_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int PREAMBLE_LEN = DEF_PREAMBLE_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              sout,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W  = $clog2(DATA_W + 1);
  localparam int ONES_W = $clog2(PREAMBLE_LEN);

  localparam logic [ONES_W-1:0] RUN_LAST  = ONES_W'(PREAMBLE_LEN - 1);
  localparam logic [CNT_W-1:0]  BITS_FULL = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0]  BITS_ONE  = CNT_W'(1);

  state_t            state, state_n;
  logic [ONES_W-1:0] pre_cnt, pre_cnt_n;
  logic [ONES_W-1:0] ones_cnt, ones_n;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_n;
  logic              load, shift;
  logic              msb, msb_next, msb_n;
  logic              sout_n;

  seq_tx_shreg #(.W(DATA_W)) u_shreg (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (in_data),
    .shift     (shift),
    .msb       (msb),
    .msb_next  (msb_next)
  );

  // State, counters and registered outputs; outputs are decoded from next-cycle values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pre_cnt  <= '0;
      ones_cnt <= '0;
      bit_cnt  <= '0;
      sout     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      state    <= state_n;
      pre_cnt  <= pre_cnt_n;
      ones_cnt <= ones_n;
      bit_cnt  <= bit_cnt_n;
      sout     <= sout_n;
      busy     <= (state_n != IDLE);
      done     <= (state_n == STOP);
      in_ready <= (state_n == IDLE);
    end
  end

  // Next-state, stuffing decisions and the value the line carries next cycle.
  always_comb begin
    state_n   = state;
    pre_cnt_n = pre_cnt;
    ones_n    = ones_cnt;
    bit_cnt_n = bit_cnt;
    load      = 1'b0;
    shift     = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          load      = 1'b1;
          pre_cnt_n = '0;
          ones_n    = '0;
          bit_cnt_n = BITS_FULL;
          state_n   = PRE;
        end
      end
      PRE: begin
        if (pre_cnt == RUN_LAST) state_n = GUARD;
        else                     pre_cnt_n = pre_cnt + 1'b1;
      end
      GUARD: state_n = DATA;
      DATA: begin
        // A run of PREAMBLE_LEN-1 ones only survives into DATA when bits remain,
        // because the last payload bit always moves to STOP.
        if (ones_cnt == RUN_LAST) begin
          ones_n = '0;
        end else begin
          shift     = 1'b1;
          bit_cnt_n = bit_cnt - 1'b1;
          ones_n    = msb ? ones_cnt + 1'b1 : '0;
          if (bit_cnt == BITS_ONE) state_n = STOP;
        end
      end
      STOP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    msb_n  = shift ? msb_next : msb;
    sout_n = (state_n == PRE) ||
             ((state_n == DATA) && (ones_n != RUN_LAST) && msb_n);
  end

endmodule

// File: tb/tb_seq_frame_tx.sv
// Directed bench for seq_frame_tx: vector table of hand-computed frames, handshake,
// back-to-back, mid-frame reset, and a random-word loopback through a 3-ones run detector.
module tb_seq_frame_tx;

  localparam int PL   = 3;
  localparam int PAY0 = PL + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       sout;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  data;
    int          len;
    logic [31:0] bits;
  } vec_t;

  vec_t vecs[6];

  seq_frame_tx #(.DATA_W(8), .PREAMBLE_LEN(PL)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sout     (sout),
    .busy     (busy),
    .done     (done)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference framing: line bits right-aligned, first transmitted bit highest.
  function automatic void model(input logic [7:0] d, output int len, output logic [31:0] bits);
    int ones;
    bits = '0;
    len  = 0;
    for (int k = 0; k < PL; k++) begin bits = {bits[30:0], 1'b1}; len++; end
    bits = {bits[30:0], 1'b0}; len++;
    ones = 0;
    for (int i = 7; i >= 0; i--) begin
      bits = {bits[30:0], d[i]}; len++;
      ones = d[i] ? ones + 1 : 0;
      if (ones == PL - 1 && i > 0) begin
        bits = {bits[30:0], 1'b0}; len++;
        ones = 0;
      end
    end
    bits = {bits[30:0], 1'b0}; len++;
  endfunction

  // Samples one frame at negedges, starting at the first cycle after the handshake edge.
  task automatic capture(output int len, output logic [31:0] bits, output int busy_bad,
                         output int max_run, output int dets, output int det_pos);
    int run;
    int prun;
    len = 0; bits = '0; busy_bad = 0; max_run = 0; dets = 0; det_pos = -1;
    run = 0; prun = 0;
    for (int i = 0; i < 40; i++) begin
      bits = {bits[30:0], sout};
      len++;
      if (!busy || in_ready) busy_bad++;
      if (sout) begin
        run++;
        if (run == PL) begin dets++; det_pos = i; end
      end else begin
        run = 0;
      end
      if (i >= PAY0) begin
        prun = sout ? prun + 1 : 0;
        if (prun > max_run) max_run = prun;
      end
      if (done) break;
      @(negedge clk);
    end
  endtask

  task automatic wait_ready(input string tag);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin @(negedge clk); w++; end
    check({tag, " ready"}, in_ready, 1'b1);
  endtask

  task automatic check_frame(input string tag, input int len, input logic [31:0] bits,
                             input int busy_bad, input int max_run, input int dets,
                             input int det_pos, input int exp_len, input logic [31:0] exp_bits);
    check({tag, " len"}, len, exp_len);
    check({tag, " bits"}, bits, exp_bits);
    check({tag, " busy"}, busy_bad, 0);
    check({tag, " no_run3_payload"}, (max_run < PL), 1'b1);
    check({tag, " det_count"}, dets, 1);
    check({tag, " det_pos"}, det_pos, PL - 1);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] d, input int exp_len,
                           input logic [31:0] exp_bits);
    int len, busy_bad, max_run, dets, det_pos;
    logic [31:0] bits;
    wait_ready(tag);
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    capture(len, bits, busy_bad, max_run, dets, det_pos);
    check_frame(tag, len, bits, busy_bad, max_run, dets, det_pos, exp_len, exp_bits);
    @(negedge clk);
    check({tag, " idle_ready"}, in_ready, 1'b1);
    check({tag, " idle_sout"}, sout, 1'b0);
    check({tag, " idle_done"}, done, 1'b0);
  endtask

  initial begin
    int len, busy_bad, max_run, dets, det_pos, elen;
    logic [31:0] bits, ebits;
    logic [7:0] d;

    vecs[0] = '{8'hA5, 13, 32'b1110_1010_0101_0};
    vecs[1] = '{8'hFF, 16, 32'b1110_1101_1011_0110};
    vecs[2] = '{8'h66, 15, 32'b111_0011_0001_1000};
    vecs[3] = '{8'h7E, 16, 32'b1110_0110_1101_1000};
    vecs[4] = '{8'h00, 13, 32'b1_1100_0000_0000};
    vecs[5] = '{8'h01, 13, 32'b1_1100_0000_0010};

    // Reset
    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    repeat (2) @(negedge clk);
    check("rst sout", sout, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst ready", in_ready, 1'b0);
    rst = 1'b0;
    #1 check("rst ready_before_edge", in_ready, 1'b0);
    @(negedge clk);
    check("rst ready_after_edge", in_ready, 1'b1);

    // Table of hand-computed frames
    for (int v = 0; v < 6; v++)
      run_frame($sformatf("vec%0d", v), vecs[v].data, vecs[v].len, vecs[v].bits);

    // in_valid held through a frame with data changed mid-frame, then back-to-back
    wait_ready("hold");
    in_data  = 8'hA5;
    in_valid = 1'b1;
    @(negedge clk);
    in_data = 8'hFF;
    capture(len, bits, busy_bad, max_run, dets, det_pos);
    check_frame("hold", len, bits, busy_bad, max_run, dets, det_pos, vecs[0].len, vecs[0].bits);
    @(negedge clk);
    check("b2b gap_ready", in_ready, 1'b1);
    check("b2b gap_sout", sout, 1'b0);
    check("b2b gap_busy", busy, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    capture(len, bits, busy_bad, max_run, dets, det_pos);
    check_frame("b2b", len, bits, busy_bad, max_run, dets, det_pos, vecs[1].len, vecs[1].bits);
    @(negedge clk);
    check("b2b idle_ready", in_ready, 1'b1);

    // Reset asserted between edges during DATA
    wait_ready("mrst");
    in_data  = 8'hFF;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("mrst in_data_phase_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("mrst async_sout", sout, 1'b0);
    check("mrst async_busy", busy, 1'b0);
    check("mrst async_ready", in_ready, 1'b0);
    check("mrst async_done", done, 1'b0);
    @(negedge clk);
    check("mrst held_sout", sout, 1'b0);
    rst = 1'b0;
    #1 check("mrst ready_before_edge", in_ready, 1'b0);
    @(negedge clk);
    check("mrst ready_after_edge", in_ready, 1'b1);
    check("mrst idle_sout", sout, 1'b0);
    run_frame("mrst_01", 8'h01, vecs[5].len, vecs[5].bits);

    // Loopback of random words through the run-of-ones detector
    for (int n = 0; n < 50; n++) begin
      d = 8'($urandom_range(0, 255));
      model(d, elen, ebits);
      run_frame($sformatf("loop%0d_%02h", n, d), d, elen, ebits);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/seq_frame_tx.md
Name: seq_frame_tx

Overview:
- Serial frame transmitter; it is the sending end for the consecutive-ones sequence detectors in the fsm block family.
- Accepts a parallel word over a valid/ready handshake.
- Emits the frame on a single-bit line: a run of ones (preamble), a guard zero, the payload MSB first with zero-stuffing, then a stop zero.
- Zero-stuffing guarantees the payload never contains a run of PREAMBLE_LEN ones, so a downstream run-of-ones detector fires only on the preamble.

Parameters:
- DATA_W, 8: payload width in bits, must be at least 2.
- PREAMBLE_LEN, 3: number of consecutive ones in the preamble, must be at least 2.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: reset, asynchronous, active-high.
- in_data, input, DATA_W: word to send. Sampled only on handshake.
- in_valid, input, 1: in_data is valid.
- in_ready, output, 1: block can accept a word.
- sout, output, 1: serial line, registered.
- busy, output, 1: a frame is in progress.
- done, output, 1: one-cycle pulse during the stop bit.

Behaviour:
- Reset:
  - rst high immediately forces state IDLE and clears the shift register and counters.
  - Outputs during reset: sout=0, busy=0, done=0, in_ready=0.
  - in_ready rises on the first clock edge after rst falls.
  - Reset mid-frame aborts the frame with no further output; the line idles at 0.
- States:
  - IDLE: sout=0, in_ready=1, busy=0. Handshake = in_valid && in_ready at a rising edge; load in_data, clear counters, go to PRE.
  - PRE: sout=1 for exactly PREAMBLE_LEN cycles, then GUARD.
  - GUARD: sout=0 for 1 cycle, then DATA.
  - DATA: payload, MSB first. See stuffing rules below.
  - STOP: sout=0 and done=1 for 1 cycle, then IDLE.
- Handshake and status:
  - in_ready is high only in IDLE (registered decode, no combinational path from in_valid).
  - in_valid outside IDLE is ignored; the word is not latched.
  - busy=1 in PRE, GUARD, DATA and STOP.
- Latency: with a handshake at edge E0, the first preamble 1 appears on sout in the cycle after E0.
- Stuffing rules in DATA:
  - ones_cnt counts consecutive transmitted payload 1s. It is cleared by a payload 0, by a stuff bit, and on load.
  - When ones_cnt reaches PREAMBLE_LEN-1 and payload bits remain, the next cycle emits a stuff 0 that consumes no payload bit; ones_cnt is then cleared.
  - No stuff bit follows the final payload bit; STOP provides the zero.
  - A bit counter of width clog2(DATA_W+1) tracks remaining payload bits. The DATA to STOP transition happens after the last payload bit.
- Frame length: PREAMBLE_LEN + 1 + DATA_W + stuff_count + 1 cycles.
- Minimum gap between frames: one IDLE cycle.

Decomposition:
- Shared package fsm_pkg holds:
  - state encoding constants IDLE, PRE, GUARD, DATA, STOP (3-bit);
  - default DATA_W and PREAMBLE_LEN constants, shared with the detector blocks.
- One natural sub-module, seq_tx_shreg: a parallel-in serial-out register with load, shift-enable (held during stuff cycles) and msb output.
- The FSM, ones_cnt and bit counter stay in seq_frame_tx.

Test Plan:
- No stuffing: in_data=8'hA5. sout = 1,1,1,0, 1,0,1,0,0,1,0,1, 0, which is 13 cycles. done is high on the 13th cycle only. in_ready returns to 1 on the following cycle.
- Full stuffing: in_data=8'hFF. sout = 1,1,1,0, 1,1,0,1,1,0,1,1,0,1,1, 0, which is 16 cycles. Exactly 3 stuff bits and no stuff after the last payload bit.
- Boundary pattern: in_data=8'h66. Payload 0,1,1,0,0,1,1,0 becomes 0,1,1,0(stuff),0,0,1,1,0(stuff),0, giving 15 cycles in total. Checker: sout never shows three consecutive 1s after the GUARD bit.
- Handshake rules:
  - in_valid held high through a frame with in_data changed mid-frame: the second word is not latched, and the frame payload is the original word.
  - Back-to-back: after STOP, one IDLE cycle with in_ready=1, then the next frame starts.
- Reset mid-frame: assert rst asynchronously during DATA, between clock edges. sout and busy go to 0 before the next clk edge. After rst falls, in_ready=1 on the first edge and a new 8'h01 frame sends correctly.
- Loopback: drive sout into the 3-ones fsm detector for 50 random words. The detector output asserts once per frame, only following the preamble.
